// File: rtl/inert_pkg.sv
// rtl/inert_pkg.sv - shared types, config ROM and axis address helpers for the inertial interface
package inert_pkg;

  typedef enum logic [2:0] {PWR_WAIT, CFG, IDLE, RD, PUBLISH, FAULT} state_t;

  localparam logic [15:0] CFG_INT1  = 16'h0D02;
  localparam logic [15:0] CFG_GYRO  = 16'h1160;
  localparam logic [15:0] CFG_CTRL3 = 16'h1440;
  localparam logic [15:0] CFG_ACCEL = 16'h1060;

  localparam logic [6:0] AXIS_BASE_ADDR = 7'h22;
  localparam logic       RD_BIT         = 1'b1;

  localparam int AXIS_GYRO_X = 0;
  localparam int AXIS_GYRO_Y = 1;
  localparam int AXIS_GYRO_Z = 2;
  localparam int AXIS_ACC_X  = 3;
  localparam int AXIS_ACC_Y  = 4;
  localparam int AXIS_ACC_Z  = 5;
  localparam int AXIS_NUM    = 6;
  localparam logic [2:0] AXIS_NONE = 3'd6;

  function automatic logic [15:0] cfg_word(input logic [1:0] idx);
    case (idx)
      2'd0:    return CFG_INT1;
      2'd1:    return CFG_GYRO;
      2'd2:    return CFG_CTRL3;
      default: return CFG_ACCEL;
    endcase
  endfunction

  // Lowest enabled axis at or above 'from'; AXIS_NONE when the mask is exhausted.
  function automatic logic [2:0] next_axis(input logic [5:0] mask, input logic [2:0] from);
    logic [2:0] r;
    r = AXIS_NONE;
    for (int i = AXIS_NUM - 1; i >= 0; i--)
      if (mask[i] && i >= int'(from)) r = 3'(i);
    return r;
  endfunction

  function automatic logic [15:0] rd_word(input logic [2:0] axis, input logic hl);
    return {RD_BIT, 7'(AXIS_BASE_ADDR + 7'({axis, hl})), 8'h00};
  endfunction

endpackage

// File: rtl/SPI_mnrch.sv
// rtl/SPI_mnrch.sv - 16-bit SPI master, SCLK = clk/16, idle-high clock, sample on rise, shift on fall
module SPI_mnrch (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wrt,
  input  logic [15:0] wt_data,
  input  logic        MISO,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  output logic        done,
  output logic [15:0] rd_data
);

  logic        busy;
  logic [3:0]  sclk_div;
  logic [3:0]  bit_cnt;
  logic [15:0] shft;
  logic        miso_smpl;

  assign SCLK    = sclk_div[3];
  assign MOSI    = shft[15];
  assign rd_data = shft;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      SS_n      <= 1'b1;
      sclk_div  <= 4'b1000;
      bit_cnt   <= 4'd0;
      shft      <= 16'h0000;
      miso_smpl <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (!busy) begin
        if (wrt) begin
          busy     <= 1'b1;
          SS_n     <= 1'b0;
          sclk_div <= 4'b0000;
          bit_cnt  <= 4'd0;
          shft     <= wt_data;
        end
      end else begin
        sclk_div <= sclk_div + 4'd1;
        if (sclk_div == 4'b0111) miso_smpl <= MISO;
        if (sclk_div == 4'b1111) begin
          shft    <= {shft[14:0], miso_smpl};
          bit_cnt <= bit_cnt + 4'd1;
          // Last bit: park SCLK high so no trailing falling edge reaches the sensor.
          if (bit_cnt == 4'hF) begin
            busy     <= 1'b0;
            SS_n     <= 1'b1;
            done     <= 1'b1;
            sclk_div <= 4'b1000;
          end
        end
      end
    end
  end

endmodule

// File: rtl/inert_multi_intf.sv
// rtl/inert_multi_intf.sv - 6-axis inertial sensor front end: SPI config, INT-driven burst read, atomic publish
module inert_multi_intf
  import inert_pkg::*;
#(
  parameter logic [5:0] AXIS_EN     = 6'b000100,
  parameter bit         FAST_SIM    = 1'b0,
  parameter int         TIMEOUT_CYC = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        re_init,
  input  logic        INT,
  input  logic        MISO,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  output logic [95:0] axis_data,
  output logic        vld,
  output logic        cfg_done,
  output logic        err
);

  localparam int         TO_W       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [2:0] CFG_N      = (AXIS_EN[5:3] != 3'b000) ? 3'd4 : 3'd3;
  localparam logic [2:0] FIRST_AXIS = next_axis(AXIS_EN, 3'd0);

  if (AXIS_EN == 6'b000000) begin : g_axis_en_check
    $error("inert_multi_intf: AXIS_EN must enable at least one axis");
  end

  state_t          state;
  logic [15:0]     timer;
  logic            int_s1, int_s;
  logic            wrt;
  logic [15:0]     wt_data;
  logic            done;
  logic [15:0]     rd_data;
  logic [2:0]      cfg_idx;
  logic [2:0]      axis_cur;
  logic            hl;
  logic [95:0]     shadow;
  logic [TO_W-1:0] to_cnt;
  logic            pwr_ok;
  logic            timed_out;
  logic [2:0]      nxt_axis;
  logic            unused_rd_hi;

  assign pwr_ok       = FAST_SIM ? (&timer[8:0]) : (&timer);
  assign timed_out    = (to_cnt == TO_W'(TIMEOUT_CYC - 1));
  assign nxt_axis     = next_axis(AXIS_EN, axis_cur + 3'd1);
  assign unused_rd_hi = ^rd_data[15:8];

  SPI_mnrch u_spi (
    .clk     (clk),
    .rst_n   (~rst),
    .wrt     (wrt),
    .wt_data (wt_data),
    .MISO    (MISO),
    .SS_n    (SS_n),
    .SCLK    (SCLK),
    .MOSI    (MOSI),
    .done    (done),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= PWR_WAIT;
      timer     <= 16'h0000;
      int_s1    <= 1'b0;
      int_s     <= 1'b0;
      wrt       <= 1'b0;
      wt_data   <= 16'h0000;
      cfg_idx   <= 3'd0;
      axis_cur  <= 3'd0;
      hl        <= 1'b0;
      shadow    <= '0;
      to_cnt    <= '0;
      axis_data <= '0;
      vld       <= 1'b0;
      cfg_done  <= 1'b0;
      err       <= 1'b0;
    end else begin
      int_s1 <= INT;
      int_s  <= int_s1;
      wrt    <= 1'b0;
      vld    <= 1'b0;
      timer  <= timer + 16'd1;
      if (re_init) begin
        // axis_data and shadow are deliberately kept; a stale in-flight done lands in PWR_WAIT and is dropped.
        state    <= PWR_WAIT;
        timer    <= 16'h0000;
        err      <= 1'b0;
        cfg_done <= 1'b0;
        to_cnt   <= '0;
      end else begin
        case (state)
          PWR_WAIT: if (pwr_ok) begin
            wrt     <= 1'b1;
            wt_data <= cfg_word(2'd0);
            cfg_idx <= 3'd1;
            to_cnt  <= '0;
            state   <= CFG;
          end
          CFG: if (done) begin
            if (cfg_idx == CFG_N) begin
              cfg_done <= 1'b1;
              state    <= IDLE;
            end else begin
              wrt     <= 1'b1;
              wt_data <= cfg_word(cfg_idx[1:0]);
              cfg_idx <= cfg_idx + 3'd1;
              to_cnt  <= '0;
            end
          end else if (timed_out) begin
            err      <= 1'b1;
            cfg_done <= 1'b0;
            state    <= FAULT;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
          IDLE: if (int_s) begin
            wrt      <= 1'b1;
            wt_data  <= rd_word(FIRST_AXIS, 1'b0);
            axis_cur <= FIRST_AXIS;
            hl       <= 1'b0;
            to_cnt   <= '0;
            state    <= RD;
          end
          RD: if (done) begin
            shadow[{axis_cur, hl, 3'b000} +: 8] <= rd_data[7:0];
            to_cnt <= '0;
            if (!hl) begin
              hl      <= 1'b1;
              wrt     <= 1'b1;
              wt_data <= rd_word(axis_cur, 1'b1);
            end else if (nxt_axis == AXIS_NONE) begin
              state <= PUBLISH;
            end else begin
              axis_cur <= nxt_axis;
              hl       <= 1'b0;
              wrt      <= 1'b1;
              wt_data  <= rd_word(nxt_axis, 1'b0);
            end
          end else if (timed_out) begin
            err      <= 1'b1;
            cfg_done <= 1'b0;
            state    <= FAULT;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
          PUBLISH: begin
            axis_data <= shadow;
            vld       <= 1'b1;
            state     <= IDLE;
          end
          FAULT: ;
          default: state <= PWR_WAIT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inert_multi_intf.sv
// tb/tb_inert_multi_intf.sv - directed self-checking bench with an SPI sensor model
module tb_inert_multi_intf;

  logic clk;
  logic rst_a, rst_b, rst_c;
  logic re_init, int_line, miso;
  int   sel;
  int   total, bad;

  logic ss_a, sclk_a, mosi_a, vld_a, cfg_a, err_a;
  logic ss_b, sclk_b, mosi_b, vld_b, cfg_b, err_b;
  logic ss_c, sclk_c, mosi_c, vld_c, cfg_c, err_c;
  logic [95:0] axis_a, axis_b, axis_c;

  inert_multi_intf #(.AXIS_EN(6'b000100), .FAST_SIM(1'b1), .TIMEOUT_CYC(4096)) dut_a (
    .clk(clk), .rst(rst_a), .re_init(re_init), .INT(int_line), .MISO(miso),
    .SS_n(ss_a), .SCLK(sclk_a), .MOSI(mosi_a), .axis_data(axis_a),
    .vld(vld_a), .cfg_done(cfg_a), .err(err_a));

  inert_multi_intf #(.AXIS_EN(6'b111111), .FAST_SIM(1'b1), .TIMEOUT_CYC(4096)) dut_b (
    .clk(clk), .rst(rst_b), .re_init(re_init), .INT(int_line), .MISO(miso),
    .SS_n(ss_b), .SCLK(sclk_b), .MOSI(mosi_b), .axis_data(axis_b),
    .vld(vld_b), .cfg_done(cfg_b), .err(err_b));

  // Timeout shorter than one SPI word, so the config write can never complete in time.
  inert_multi_intf #(.AXIS_EN(6'b000100), .FAST_SIM(1'b1), .TIMEOUT_CYC(200)) dut_c (
    .clk(clk), .rst(rst_c), .re_init(re_init), .INT(int_line), .MISO(miso),
    .SS_n(ss_c), .SCLK(sclk_c), .MOSI(mosi_c), .axis_data(axis_c),
    .vld(vld_c), .cfg_done(cfg_c), .err(err_c));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic ss_m, sclk_m, mosi_m, vld_m, cfg_m, err_m;
  logic [95:0] axis_m;
  assign ss_m   = (sel == 0) ? ss_a   : (sel == 1) ? ss_b   : ss_c;
  assign sclk_m = (sel == 0) ? sclk_a : (sel == 1) ? sclk_b : sclk_c;
  assign mosi_m = (sel == 0) ? mosi_a : (sel == 1) ? mosi_b : mosi_c;
  assign vld_m  = (sel == 0) ? vld_a  : (sel == 1) ? vld_b  : vld_c;
  assign cfg_m  = (sel == 0) ? cfg_a  : (sel == 1) ? cfg_b  : cfg_c;
  assign err_m  = (sel == 0) ? err_a  : (sel == 1) ? err_b  : err_c;
  assign axis_m = (sel == 0) ? axis_a : (sel == 1) ? axis_b : axis_c;

  // Sensor model: shifts MOSI in on SCLK rise, answers the register byte on the falls of the second half.
  logic [15:0] axis_val [6];
  logic [15:0] rx;
  logic [7:0]  resp;
  int          bitc;
  logic [15:0] wlog [64];
  int          wcnt;

  function automatic logic [7:0] model_byte(input logic [6:0] addr);
    logic [6:0] off;
    off = addr - 7'h22;
    if (addr < 7'h22 || addr > 7'h2D) return 8'h00;
    return off[0] ? axis_val[off[3:1]][15:8] : axis_val[off[3:1]][7:0];
  endfunction

  always @(negedge ss_m) begin
    bitc = 0;
    rx   = 16'h0000;
  end

  always @(posedge sclk_m) if (!ss_m) begin
    rx   = {rx[14:0], mosi_m};
    bitc = bitc + 1;
    if (bitc == 8) resp = model_byte(rx[6:0]);
  end

  always @(negedge sclk_m) if (!ss_m && bitc >= 8 && bitc < 16) miso = resp[15 - bitc];

  always @(posedge ss_m) begin
    if (wcnt < 64) wlog[wcnt] = rx;
    wcnt = wcnt + 1;
  end

  int   cyc, last_rise, vld_cnt, gap_bad, chg_bad, vld_long;
  logic ss_prev, vld_prev;
  logic [95:0] axis_prev;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (ss_m && !ss_prev) last_rise = cyc;
    ss_prev = ss_m;
    if (vld_m) begin
      vld_cnt = vld_cnt + 1;
      if (cyc - last_rise != 2) gap_bad = gap_bad + 1;
      if (vld_prev) vld_long = vld_long + 1;
    end else if (axis_m !== axis_prev) begin
      chg_bad = chg_bad + 1;
    end
    vld_prev  = vld_m;
    axis_prev = axis_m;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    tick(3);
    total++; if (axis_a !== 96'h0) begin bad++; $display("FAIL reset_axis got=%h exp=0", axis_a); end
    total++; if (vld_a !== 1'b0) begin bad++; $display("FAIL reset_vld got=%b exp=0", vld_a); end
    total++; if (cfg_a !== 1'b0) begin bad++; $display("FAIL reset_cfg_done got=%b exp=0", cfg_a); end
    total++; if (err_a !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err_a); end
    total++; if (ss_a !== 1'b1) begin bad++; $display("FAIL reset_ss_n got=%b exp=1", ss_a); end
    wcnt  = 0;
    rst_a = 1'b0;
  endtask

  task automatic test_config();
    tick(505);
    total++; if (ss_m !== 1'b1) begin bad++; $display("FAIL pwr_wait_ss_n got=%b exp=1", ss_m); end
    total++; if (wcnt !== 0) begin bad++; $display("FAIL pwr_wait_words got=%0d exp=0", wcnt); end
    tick(10);
    total++; if (ss_m !== 1'b0) begin bad++; $display("FAIL cfg_start_ss_n got=%b exp=0", ss_m); end
    for (int i = 0; i < 2000 && cfg_m !== 1'b1; i++) tick(1);
    total++; if (cfg_m !== 1'b1) begin bad++; $display("FAIL cfg_done_timeout got=%b exp=1", cfg_m); end
    tick(400);
    total++; if (wcnt !== 3) begin bad++; $display("FAIL cfg_word_count got=%0d exp=3", wcnt); end
    total++; if (wlog[0] !== 16'h0D02) begin bad++; $display("FAIL cfg_w0 got=%h exp=0d02", wlog[0]); end
    total++; if (wlog[1] !== 16'h1160) begin bad++; $display("FAIL cfg_w1 got=%h exp=1160", wlog[1]); end
    total++; if (wlog[2] !== 16'h1440) begin bad++; $display("FAIL cfg_w2 got=%h exp=1440", wlog[2]); end
  endtask

  task automatic test_single_axis();
    axis_val[0] = 16'h1111; axis_val[1] = 16'h2222; axis_val[2] = 16'h8123;
    axis_val[3] = 16'h4444; axis_val[4] = 16'h5555; axis_val[5] = 16'h6666;
    vld_cnt = 0; chg_bad = 0; gap_bad = 0; vld_long = 0; wcnt = 0;
    int_line = 1'b1;
    tick(3);
    total++; if (ss_m !== 1'b1) begin bad++; $display("FAIL int_latency_early got=%b exp=1", ss_m); end
    tick(1);
    total++; if (ss_m !== 1'b0) begin bad++; $display("FAIL int_latency got=%b exp=0", ss_m); end
    int_line = 1'b0;
    for (int i = 0; i < 1000 && vld_cnt == 0; i++) tick(1);
    tick(600);
    total++; if (vld_cnt !== 1) begin bad++; $display("FAIL single_vld_count got=%0d exp=1", vld_cnt); end
    total++; if (wcnt !== 2) begin bad++; $display("FAIL single_word_count got=%0d exp=2", wcnt); end
    total++; if (wlog[0] !== 16'hA600) begin bad++; $display("FAIL single_rd_l got=%h exp=a600", wlog[0]); end
    total++; if (wlog[1] !== 16'hA700) begin bad++; $display("FAIL single_rd_h got=%h exp=a700", wlog[1]); end
    total++; if (axis_m !== 96'h0000_0000_0000_8123_0000_0000) begin
      bad++; $display("FAIL single_axis_data got=%h exp=000000000000812300000000", axis_m);
    end
    total++; if (gap_bad !== 0) begin bad++; $display("FAIL vld_after_done_gap got=%0d exp=0", gap_bad); end
    total++; if (chg_bad !== 0) begin bad++; $display("FAIL single_partial_update got=%0d exp=0", chg_bad); end
  endtask

  task automatic test_all_axes();
    logic [15:0] exp_w;
    rst_a = 1'b1;
    sel   = 1;
    tick(2);
    wcnt  = 0;
    rst_b = 1'b0;
    axis_val[0] = 16'hF001; axis_val[1] = 16'h7E02; axis_val[2] = 16'h8D03;
    axis_val[3] = 16'h1C04; axis_val[4] = 16'hAB05; axis_val[5] = 16'h5A06;
    for (int i = 0; i < 3000 && cfg_m !== 1'b1; i++) tick(1);
    total++; if (wcnt !== 4) begin bad++; $display("FAIL all_cfg_count got=%0d exp=4", wcnt); end
    total++; if (wlog[3] !== 16'h1060) begin bad++; $display("FAIL all_cfg_accel got=%h exp=1060", wlog[3]); end
    tick(2);
    vld_cnt = 0; chg_bad = 0; gap_bad = 0; wcnt = 0;
    int_line = 1'b1;
    for (int i = 0; i < 10 && ss_m !== 1'b0; i++) tick(1);
    int_line = 1'b0;
    for (int i = 0; i < 4000 && vld_cnt == 0; i++) tick(1);
    tick(300);
    total++; if (wcnt !== 12) begin bad++; $display("FAIL all_word_count got=%0d exp=12", wcnt); end
    for (int k = 0; k < 12; k++) begin
      exp_w = {1'b1, 7'(7'h22 + k), 8'h00};
      total++; if (wlog[k] !== exp_w) begin bad++; $display("FAIL all_rd_addr[%0d] got=%h exp=%h", k, wlog[k], exp_w); end
    end
    total++; if (vld_cnt !== 1) begin bad++; $display("FAIL all_vld_count got=%0d exp=1", vld_cnt); end
    total++; if (axis_m !== 96'h5A06_AB05_1C04_8D03_7E02_F001) begin
      bad++; $display("FAIL all_axis_data got=%h exp=5a06ab051c048d037e02f001", axis_m);
    end
    total++; if (gap_bad !== 0) begin bad++; $display("FAIL all_vld_gap got=%0d exp=0", gap_bad); end
  endtask

  task automatic test_back_to_back();
    vld_cnt = 0; chg_bad = 0; vld_long = 0;
    int_line = 1'b1;
    for (int i = 0; i < 4000 && vld_cnt < 1; i++) tick(1);
    axis_val[0] = 16'h0111; axis_val[1] = 16'h0222; axis_val[2] = 16'h0333;
    axis_val[3] = 16'h0444; axis_val[4] = 16'h0555; axis_val[5] = 16'h0666;
    for (int i = 0; i < 4000 && vld_cnt < 2; i++) tick(1);
    total++; if (axis_m !== 96'h0666_0555_0444_0333_0222_0111) begin
      bad++; $display("FAIL b2b_axis_data got=%h exp=066605550444033302220111", axis_m);
    end
    int_line = 1'b0;
    for (int i = 0; i < 4000 && vld_cnt < 3; i++) tick(1);
    tick(3500);
    total++; if (vld_cnt !== 3) begin bad++; $display("FAIL b2b_vld_count got=%0d exp=3", vld_cnt); end
    total++; if (chg_bad !== 0) begin bad++; $display("FAIL b2b_change_without_vld got=%0d exp=0", chg_bad); end
    total++; if (vld_long !== 0) begin bad++; $display("FAIL b2b_vld_width got=%0d exp=0", vld_long); end
  endtask

  task automatic test_rst_mid_burst();
    int_line = 1'b1;
    for (int i = 0; i < 20 && ss_m !== 1'b0; i++) tick(1);
    tick(100);
    rst_b = 1'b1;
    #1;
    total++; if (ss_m !== 1'b1) begin bad++; $display("FAIL rst_ss_n got=%b exp=1", ss_m); end
    total++; if (axis_m !== 96'h0) begin bad++; $display("FAIL rst_axis got=%h exp=0", axis_m); end
    total++; if (cfg_m !== 1'b0) begin bad++; $display("FAIL rst_cfg_done got=%b exp=0", cfg_m); end
    total++; if (vld_m !== 1'b0 || err_m !== 1'b0) begin
      bad++; $display("FAIL rst_vld_err got=%b%b exp=00", vld_m, err_m);
    end
    int_line = 1'b0;
    tick(2);
    wcnt  = 0;
    rst_b = 1'b0;
    tick(505);
    total++; if (wcnt !== 0 || ss_m !== 1'b1) begin
      bad++; $display("FAIL rst_restart_wait got=%0d/%b exp=0/1", wcnt, ss_m);
    end
    for (int i = 0; i < 3000 && cfg_m !== 1'b1; i++) tick(1);
    total++; if (wlog[0] !== 16'h0D02 || wcnt !== 4) begin
      bad++; $display("FAIL rst_reconfig got=%h/%0d exp=0d02/4", wlog[0], wcnt);
    end
  endtask

  task automatic test_timeout();
    rst_b = 1'b1;
    sel   = 2;
    tick(2);
    wcnt  = 0;
    rst_c = 1'b0;
    tick(705);
    total++; if (err_m !== 1'b0) begin bad++; $display("FAIL to_early_err got=%b exp=0", err_m); end
    tick(15);
    total++; if (err_m !== 1'b1) begin bad++; $display("FAIL to_err got=%b exp=1", err_m); end
    total++; if (cfg_m !== 1'b0) begin bad++; $display("FAIL to_cfg_done got=%b exp=0", cfg_m); end
    tick(200);
    total++; if (err_m !== 1'b1 || wcnt !== 1) begin
      bad++; $display("FAIL to_fault_hold got=%b/%0d exp=1/1", err_m, wcnt);
    end
    re_init = 1'b1;
    tick(1);
    re_init = 1'b0;
    total++; if (err_m !== 1'b0) begin bad++; $display("FAIL reinit_err got=%b exp=0", err_m); end
    wcnt = 0;
    tick(505);
    total++; if (ss_m !== 1'b1 || wcnt !== 0) begin
      bad++; $display("FAIL reinit_wait got=%b/%0d exp=1/0", ss_m, wcnt);
    end
    tick(15);
    total++; if (ss_m !== 1'b0) begin bad++; $display("FAIL reinit_cfg_start got=%b exp=0", ss_m); end
    for (int i = 0; i < 400 && wcnt < 1; i++) tick(1);
    total++; if (wlog[0] !== 16'h0D02) begin bad++; $display("FAIL reinit_w0 got=%h exp=0d02", wlog[0]); end
  endtask

  initial begin
    total = 0; bad = 0; sel = 0; wcnt = 0; bitc = 0; rx = 16'h0; resp = 8'h0;
    cyc = 0; last_rise = 0; vld_cnt = 0; gap_bad = 0; chg_bad = 0; vld_long = 0;
    ss_prev = 1'b1; vld_prev = 1'b0; axis_prev = 96'h0;
    for (int i = 0; i < 6; i++) axis_val[i] = 16'h0000;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    re_init = 1'b0; int_line = 1'b0; miso = 1'b0;
    test_reset();
    test_config();
    test_single_axis();
    test_all_axes();
    test_back_to_back();
    test_rst_mid_burst();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
